// File: rtl/register_file_sb_if.sv
// Bus bundle for register_file_sb: two read ports, two write ports and the reserve port.
// The master drives addresses, write data and enables; the slave returns read data and busy bits.
interface register_file_sb_if #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned ADDR_W = 3
);
   logic [ADDR_W-1:0] rd_ad1;
   logic [ADDR_W-1:0] rd_ad2;
   logic [DATA_W-1:0] rd_d1;
   logic [DATA_W-1:0] rd_d2;
   logic              rd_busy1;
   logic              rd_busy2;
   logic              wa_en;
   logic [ADDR_W-1:0] wa_ad;
   logic [DATA_W-1:0] wa_d;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_ad;
   logic [DATA_W-1:0] wb_d;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_ad;
   logic              busy_any;

   modport master (
      output rd_ad1, rd_ad2, wa_en, wa_ad, wa_d, wb_en, wb_ad, wb_d, rsv_en, rsv_ad,
      input  rd_d1, rd_d2, rd_busy1, rd_busy2, busy_any
   );

   modport slave (
      input  rd_ad1, rd_ad2, wa_en, wa_ad, wa_d, wb_en, wb_ad, wb_d, rsv_en, rsv_ad,
      output rd_d1, rd_d2, rd_busy1, rd_busy2, busy_any
   );
endinterface

// File: rtl/register_file_sb.sv
// Register file with two async read ports, two clocked write ports (B wins on conflict),
// optional write-to-read bypass, optional hard-wired zero register and a per-register busy bit.
module register_file_sb #(
   parameter int unsigned DATA_W   = 4,
   parameter int unsigned ADDR_W   = 3,
   parameter bit          BYPASS   = 1'b1,
   parameter bit          ZERO_REG = 1'b0
) (
   input logic               clk,
   input logic               rst,
   register_file_sb_if.slave bus
);
   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [Depth];
   logic [DATA_W-1:0] mem_d [Depth];
   logic [Depth-1:0]  busy_q;
   logic [Depth-1:0]  busy_d;

   logic wa_ok;
   logic wb_ok;
   logic rsv_ok;

   logic [ADDR_W-1:0] rd_ad   [2];
   logic [DATA_W-1:0] rd_d    [2];
   logic [1:0]        rd_busy;
   logic              hit_a;
   logic              hit_b;
   logic              hit_r;

   // Qualified requests: nothing takes effect under reset, and address 0 is inert with ZERO_REG.
   always_comb begin
      wa_ok  = rst && bus.wa_en  && !(ZERO_REG && (bus.wa_ad  == '0));
      wb_ok  = rst && bus.wb_en  && !(ZERO_REG && (bus.wb_ad  == '0));
      rsv_ok = rst && bus.rsv_en && !(ZERO_REG && (bus.rsv_ad == '0));
   end

   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      if (wa_ok) begin
         mem_d[bus.wa_ad]  = bus.wa_d;
         busy_d[bus.wa_ad] = 1'b0;
      end
      if (wb_ok) begin
         mem_d[bus.wb_ad]  = bus.wb_d;
         busy_d[bus.wb_ad] = 1'b0;
      end
      // Reservation is applied last so a same-cycle write cannot cancel it.
      if (rsv_ok) begin
         busy_d[bus.rsv_ad] = 1'b1;
      end
      if (ZERO_REG) begin
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q  <= '{default: '0};
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   always_comb begin
      rd_ad[0] = bus.rd_ad1;
      rd_ad[1] = bus.rd_ad2;
      hit_a    = 1'b0;
      hit_b    = 1'b0;
      hit_r    = 1'b0;
      for (int p = 0; p < 2; p++) begin
         rd_d[p]    = mem_q[rd_ad[p]];
         rd_busy[p] = busy_q[rd_ad[p]];
         if (BYPASS) begin
            hit_a = wa_ok  && (bus.wa_ad  == rd_ad[p]);
            hit_b = wb_ok  && (bus.wb_ad  == rd_ad[p]);
            hit_r = rsv_ok && (bus.rsv_ad == rd_ad[p]);
            if (hit_a) begin
               rd_d[p] = bus.wa_d;
            end
            if (hit_b) begin
               rd_d[p] = bus.wb_d;
            end
            // A pending write clears busy early unless a new producer reserves it this cycle.
            if ((hit_a || hit_b) && !hit_r) begin
               rd_busy[p] = 1'b0;
            end
         end
      end
   end

   assign bus.rd_d1    = rd_d[0];
   assign bus.rd_d2    = rd_d[1];
   assign bus.rd_busy1 = rd_busy[0];
   assign bus.rd_busy2 = rd_busy[1];
   assign bus.busy_any = |busy_q;

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised successor to the 8x4 register file used by the SimpleMicroProcessor datapath. Width and depth are configurable. It has two asynchronous read ports and two clocked write ports: port A for ALU writeback, port B for load writeback. It adds optional write-to-read bypass, an optional hard-wired zero register, and a per-register busy (scoreboard) bit that the controller uses to stall on pending writes.

## Interface
Parameters:
- DATA_W, 4, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- BYPASS, 1, 1 = reads return same-cycle write data; 0 = reads return stored value only
- ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes and reservations

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- rd_ad1  input  ADDR_W  read address, port 1
- rd_ad2  input  ADDR_W  read address, port 2
- rd_d1  output  DATA_W  read data, port 1
- rd_d2  output  DATA_W  read data, port 2
- rd_busy1  output  1  busy bit of rd_ad1
- rd_busy2  output  1  busy bit of rd_ad2
- wa_en  input  1  write enable, port A
- wa_ad  input  ADDR_W  write address, port A
- wa_d  input  DATA_W  write data, port A
- wb_en  input  1  write enable, port B
- wb_ad  input  ADDR_W  write address, port B
- wb_d  input  DATA_W  write data, port B
- rsv_en  input  1  reserve request: set busy on rsv_ad
- rsv_ad  input  ADDR_W  register to reserve
- busy_any  output  1  OR of all busy bits

## Operation
- Storage: DEPTH x DATA_W registers plus a DEPTH-bit busy vector.
- Write: on the rising edge, if wa_en is high, reg[wa_ad] <= wa_d. If wb_en is high, reg[wb_ad] <= wb_d.
- Same-address write conflict: if wa_en, wb_en and wa_ad == wb_ad, port B wins.
- Read: combinational. rd_dN = reg[rd_adN].
  - BYPASS=1: if a write to rd_adN is enabled this cycle, rd_dN returns the incoming data (wb_d wins over wa_d).
- Busy set: rsv_en sets busy[rsv_ad] at the edge.
- Busy clear: any enabled write (A or B) to an address clears that address's busy bit at the edge.
- Reserve and write to the same address in the same cycle: busy ends set. The data is still written; the reservation is for the next producer.
- Reserving an already-busy register keeps it busy. Writing a non-busy register leaves it non-busy. Neither is an error.
- rd_busyN = busy[rd_adN]. With BYPASS=1, a same-cycle write to rd_adN with no same-cycle reserve makes rd_busyN read 0.
- ZERO_REG=1: address 0 has rd_dN = 0 and rd_busyN = 0. Writes and reserves to address 0 are dropped. busy[0] is held at 0.
- Data is stored modulo 2**DATA_W; no sign handling. Negative values are stored two's-complement truncated.
- Out-of-range addresses cannot occur, since DEPTH = 2**ADDR_W.

## Timing
- Reset: rst low asynchronously clears all registers to 0 and all busy bits to 0. The effect on outputs is immediate:
  - rd_d1 = rd_d2 = 0
  - rd_busy1 = rd_busy2 = 0
  - busy_any = 0
- While rst is low, writes and reserves are ignored. rst low in the middle of a write/reserve sequence discards all state.
- Release: the first write is captured on the first rising edge with rst high.
- Write latency:
  - BYPASS=0: 1 cycle; the stored value is visible on reads after the edge.
  - BYPASS=1: 0 cycles; visible combinationally in the same cycle.
- Busy latency: set or clear takes effect after the edge. Exception: the BYPASS=1 clear shortcut on rd_busyN is combinational.
- busy_any is combinational from the busy vector.
- Reads have no enable and no latency beyond combinational path delay.

## Test plan
- Reset/fill/readback (DATA_W=4, ADDR_W=3, BYPASS=0):
  - Hold rst low, then release. Write reg i = i for i = 0..7 via port A, then read pairs (i, i+1) -> rd_d1 = i, rd_d2 = i+1. All busy bits 0.
  - Then write reg i = -i -> reads return 0, F, E, D, C, B, A, 9.
- Port conflict: wa_en = wb_en = 1, both to address 5, wa_d = 3, wb_d = 9 -> reg5 = 9.
  - BYPASS=1: rd_ad1 = 5 shows 9 in the same cycle.
  - BYPASS=0: rd_ad1 = 5 shows the old value, then 9 after the edge.
- Scoreboard:
  - rsv 3 -> rd_busy(3) = 1 and busy_any = 1 after the edge.
  - Then wb write 3 = 7 -> busy clears and reads 7.
  - Reserve plus write to 3 in the same cycle -> reads 7 and busy stays 1.
- Zero register (ZERO_REG=1): write 4'hA to address 0 and reserve 0 -> rd_d1 = 0, rd_busy1 = 0, busy_any unchanged.
- Async reset mid-operation: reserve 2 and write 2 = 6, then pulse rst low between clock edges -> all reads 0 and busy_any = 0 immediately. Next write after release works.
